// File: rtl/rnd_range_sampler.sv
// Bounded random value sampler.
// Draws values from an upstream pseudorandom stream and keeps the first one
// that falls below the requested exclusive bound (rejection sampling). If
// MAX_RETRY consecutive samples are rejected, the last sample is reduced
// modulo the bound instead, so every request completes in bounded time.
// A zero bound cannot be satisfied and is answered immediately with err set.
module rnd_range_sampler #(
  parameter int MAX_RETRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] rnd,
  input  logic       req,
  input  logic [5:0] limit,
  output logic       busy,
  output logic       valid,
  output logic [5:0] value,
  output logic [3:0] tries,
  output logic       fallback,
  output logic       err,
  output logic [7:0] fallback_cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } state_t;

  // Retry bookkeeping is done in 5 bits so retry+1 never wraps before the
  // comparison against MAX_RETRY (which may be as large as 15).
  localparam logic [4:0] MAX_RETRY_W = 5'(MAX_RETRY);
  localparam logic [3:0] MAX_TRIES   = 4'(MAX_RETRY);

  state_t     state_r;
  logic [3:0] retry_r;
  logic [5:0] limit_q;

  logic [4:0] retry_inc_s;
  logic       reject_s;
  logic       last_try_s;

  // Remainder of x by m; a zero divisor yields zero instead of an undefined
  // result. In SAMPLE the latched bound is never zero, so the guard only keeps
  // the datapath well defined.
  function automatic logic [5:0] bounded_mod(input logic [5:0] x, input logic [5:0] m);
    logic [5:0] r;
    if (m == 6'd0) begin
      r = 6'd0;
    end else begin
      r = x % m;
    end
    return r;
  endfunction

  assign retry_inc_s = {1'b0, retry_r} + 5'd1;
  assign reject_s    = (rnd >= limit_q);
  assign last_try_s  = (retry_inc_s >= MAX_RETRY_W);

  // busy reflects the state register directly, so it is glitch-free.
  assign busy = (state_r == SAMPLE);

  // Request FSM together with the registered result outputs and fallback counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      retry_r      <= 4'd0;
      limit_q      <= 6'd0;
      valid        <= 1'b0;
      value        <= 6'd0;
      tries        <= 4'd0;
      fallback     <= 1'b0;
      err          <= 1'b0;
      fallback_cnt <= 8'd0;
    end else begin
      // valid is a single-cycle pulse; only a completing edge raises it again.
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            if (limit == 6'd0) begin
              // Empty range: answer at once, never enter SAMPLE.
              valid    <= 1'b1;
              value    <= 6'd0;
              tries    <= 4'd0;
              fallback <= 1'b0;
              err      <= 1'b1;
            end else begin
              limit_q <= limit;
              retry_r <= 4'd0;
              state_r <= SAMPLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SAMPLE: begin
          if (!reject_s) begin
            // Sample is in range: accept it as-is.
            valid    <= 1'b1;
            value    <= rnd;
            tries    <= retry_inc_s[3:0];
            fallback <= 1'b0;
            err      <= 1'b0;
            state_r  <= IDLE;
          end else if (!last_try_s) begin
            retry_r <= retry_inc_s[3:0];
          end else begin
            // Retry budget exhausted: fold the last sample into range.
            valid    <= 1'b1;
            value    <= bounded_mod(rnd, limit_q);
            tries    <= MAX_TRIES;
            fallback <= 1'b1;
            err      <= 1'b0;
            state_r  <= IDLE;
            if (fallback_cnt != 8'd255) begin
              fallback_cnt <= fallback_cnt + 8'd1;
            end else begin
              fallback_cnt <= fallback_cnt;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          retry_r <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rnd_range_sampler.sv
// Self-checking bench for rnd_range_sampler: a driver issues requests with a
// chosen sample stream, a transaction-level model predicts each outcome from
// the sampling rules and queues it, and a monitor compares every valid pulse.
module tb_rnd_range_sampler;

  localparam int MR = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] rnd;
  logic       req;
  logic [5:0] limit;
  logic       busy;
  logic       valid;
  logic [5:0] value;
  logic [3:0] tries;
  logic       fallback;
  logic       err;
  logic [7:0] fallback_cnt;

  typedef struct {
    int         cyc;
    logic [5:0] value;
    logic [3:0] tries;
    logic       fb;
    logic       err;
    logic [7:0] fbc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fb_model = 0;
  int   samp[16];

  rnd_range_sampler #(.MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .rnd(rnd), .req(req), .limit(limit),
    .busy(busy), .valid(valid), .value(value), .tries(tries),
    .fallback(fallback), .err(err), .fallback_cnt(fallback_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (edge %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: compare each valid pulse against the oldest prediction.
  always @(negedge clk) begin : mon
    exp_t e;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid at edge %0d value %0d", cyc, value);
      end else begin
        e = sb.pop_front();
        chk("valid_edge", 32'(cyc), 32'(e.cyc));
        chk("value", 32'(value), 32'(e.value));
        chk("tries", 32'(tries), 32'(e.tries));
        chk("fallback", 32'(fallback), 32'(e.fb));
        chk("err", 32'(err), 32'(e.err));
        chk("fallback_cnt", 32'(fallback_cnt), 32'(e.fbc));
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid expected at edge %0d, none by edge %0d", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
  end

  // Issue one request with bound lim; samp[] supplies the rnd values seen on
  // successive sampling edges. The outcome is predicted from the rules.
  task automatic issue(input logic [5:0] lim, input bit b2b);
    exp_t e;
    int   k;
    bit   found;
    req   = 1'b1;
    limit = lim;
    rnd   = 6'($urandom);
    @(posedge clk);
    #1;
    if (lim == 6'd0) begin
      e.cyc = cyc; e.value = 6'd0; e.tries = 4'd0; e.fb = 1'b0; e.err = 1'b1;
      e.fbc = 8'(fb_model);
      sb.push_back(e);
      chk("busy_zero_limit", 32'(busy), 32'd0);
    end else begin
      found = 1'b0;
      k = MR;
      for (int i = 0; i < MR; i++) begin
        if (!found && samp[i] < int'(lim)) begin
          found = 1'b1;
          k = i + 1;
        end
      end
      e.cyc = cyc + k;
      e.err = 1'b0;
      if (found) begin
        e.value = 6'(samp[k-1]);
        e.tries = 4'(k);
        e.fb    = 1'b0;
      end else begin
        e.value = 6'(samp[MR-1] % int'(lim));
        e.tries = 4'(MR);
        e.fb    = 1'b1;
        fb_model = (fb_model < 255) ? fb_model + 1 : 255;
      end
      e.fbc = 8'(fb_model);
      sb.push_back(e);
      chk("busy_after_accept", 32'(busy), 32'd1);
      for (int i = 0; i < k; i++) begin
        // Garbage on req/limit while busy must have no effect.
        req   = 1'($urandom_range(0, 1));
        limit = 6'($urandom);
        rnd   = 6'(samp[i]);
        @(posedge clk);
        #1;
        chk("busy_sampling", 32'(busy), (i < k - 1) ? 32'd1 : 32'd0);
      end
    end
    if (!b2b) begin
      req = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_tries"}, 32'(tries), 32'd0);
    chk({tag, "_fallback"}, 32'(fallback), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fallback_cnt"}, 32'(fallback_cnt), 32'd0);
  endtask

  initial begin
    logic [5:0] lim;
    int         r;
    // Reset with a request pending: reset must win.
    rst = 1'b1; req = 1'b1; limit = 6'd10; rnd = 6'd63;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // In-range first sample, accepted on the first edge after reset.
    samp[0] = 7;
    issue(6'd10, 1'b0);
    // Two rejections then an accept.
    samp[0] = 40; samp[1] = 55; samp[2] = 3;
    issue(6'd10, 1'b0);
    // Every sample rejected: fallback 45 mod 10 = 5.
    for (int i = 0; i < 16; i++) samp[i] = 45;
    issue(6'd10, 1'b0);
    // Zero bound: immediate error answer.
    issue(6'd0, 1'b0);
    // Bound of one: only 0 is acceptable, fallback also gives 0.
    for (int i = 0; i < 16; i++) samp[i] = 63;
    issue(6'd1, 1'b1);

    // Randomized requests, mixed idle gaps and back-to-back.
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r == 0) lim = 6'd0;
      else if (r == 1) lim = 6'd1;
      else lim = 6'($urandom_range(1, 63));
      for (int i = 0; i < 16; i++) samp[i] = $urandom_range(0, 63);
      issue(lim, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of sampling, with req and a new limit applied.
    req = 1'b1; limit = 6'd10; rnd = 6'd0;
    @(posedge clk);
    #1;
    chk("busy_before_abort", 32'(busy), 32'd1);
    req = 1'b1; limit = 6'd20; rnd = 6'd63;
    @(posedge clk);
    #1;
    chk("busy_ignores_limit", 32'(busy), 32'd1);
    rst = 1'b1; req = 1'b1; limit = 6'd5; rnd = 6'd0;
    @(posedge clk);
    #1;
    check_reset_state("abort");
    fb_model = 0;
    rst = 1'b0;

    // Saturation of the fallback counter with back-to-back forced fallbacks.
    repeat (260) begin
      lim = 6'($urandom_range(1, 63));
      for (int i = 0; i < 16; i++) samp[i] = $urandom_range(int'(lim), 63);
      issue(lim, 1'b1);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("fallback_cnt_saturated", 32'(fallback_cnt), 32'd255);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
